// File: rtl/niosbase_pio_poller_pkg.sv
// Shared constants for the PIO poller: CSR word map, register bit
// positions, PIO slave addresses, scan FSM encoding and the event record.
package niosbase_pio_poller_pkg;

  localparam logic [2:0] ADDR_CONTROL    = 3'd0;
  localparam logic [2:0] ADDR_PERIOD     = 3'd1;
  localparam logic [2:0] ADDR_STATUS     = 3'd2;
  localparam logic [2:0] ADDR_EVENT_DATA = 3'd3;
  localparam logic [2:0] ADDR_EVENT_SRC  = 3'd4;
  localparam logic [2:0] ADDR_MASK       = 3'd5;

  localparam int unsigned CTRL_ENABLE_BIT   = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
  localparam int unsigned STAT_EMPTY_BIT    = 0;
  localparam int unsigned STAT_OVERFLOW_BIT = 1;
  localparam int unsigned STAT_COUNT_LSB    = 4;
  localparam int unsigned STAT_COUNT_MSB    = 8;

  // PIO slave word 0 is the data register; word 1 is a harmless non-data word
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_IDLE = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_COMPARE
  } state_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } event_t;

  localparam int unsigned EVENT_W = $bits(event_t);

endpackage

// File: rtl/niosbase_pio_poller_fifo.sv
// Event FIFO: head is visible combinationally, push into a full FIFO is
// accepted only when a pop happens on the same edge.
module niosbase_pio_poller_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/niosbase_pio_poller.sv
// Periodically scans up to four PIO input slaves, compares each reading
// against a shadow copy and queues change events for the CPU.
module niosbase_pio_poller
  import niosbase_pio_poller_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata_0,
  input  logic [31:0] pio_readdata_1,
  input  logic [31:0] pio_readdata_2,
  input  logic [31:0] pio_readdata_3,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]  LAST_SRC  = 2'(NUM_SRC - 1);
  localparam logic [3:0]  MASK_ONES = 4'((1 << NUM_SRC) - 1);

  logic          ctrl_en;
  logic          ctrl_irq_en;
  logic [15:0]   period;
  logic [3:0]    mask;
  logic [15:0]   cnt;
  logic          tick_pend;
  state_t        state;
  logic [1:0]    k;
  logic [31:0]   cap;
  logic [31:0]   shadow [4];
  logic [3:0]    primed;
  logic          overflow;

  logic          wr_en;
  logic          rd_en;
  logic          period_wr;
  logic          ovf_clr;
  logic          push;
  logic          pop;
  logic          drop;
  logic [31:0]   src_data;
  logic [31:0]   rd_mux;
  event_t        push_ev;
  event_t        head_ev;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign period_wr = wr_en && (address == ADDR_PERIOD);
  assign ovf_clr   = wr_en && (address == ADDR_STATUS) && writedata[STAT_OVERFLOW_BIT];
  assign pop       = rd_en && (address == ADDR_EVENT_DATA) && !fifo_empty;
  assign push      = ctrl_en && (state == ST_COMPARE) && primed[k] &&
                     (cap != shadow[k]) && mask[k];
  assign drop      = push & fifo_full & ~pop;
  assign irq       = ctrl_irq_en & (~fifo_empty | overflow);

  assign push_ev.src  = k;
  assign push_ev.data = cap;

  // Select the readdata of the source currently being scanned
  always_comb begin
    src_data = '0;
    case (k)
      2'd0:    src_data = pio_readdata_0;
      2'd1:    src_data = pio_readdata_1;
      2'd2:    src_data = pio_readdata_2;
      default: src_data = pio_readdata_3;
    endcase
  end

  // CSR read data selection
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CONTROL: begin
        rd_mux[CTRL_ENABLE_BIT] = ctrl_en;
        rd_mux[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
      end
      ADDR_PERIOD: rd_mux[15:0] = period;
      ADDR_STATUS: begin
        rd_mux[STAT_EMPTY_BIT]                    = fifo_empty;
        rd_mux[STAT_OVERFLOW_BIT]                 = overflow;
        rd_mux[STAT_COUNT_MSB:STAT_COUNT_LSB]     = 5'(fifo_count);
      end
      ADDR_EVENT_DATA: if (!fifo_empty) rd_mux = head_ev.data;
      ADDR_EVENT_SRC:  if (!fifo_empty) rd_mux[1:0] = head_ev.src;
      ADDR_MASK:       rd_mux[3:0] = mask;
      default:         rd_mux = '0;
    endcase
  end

  // CSR writes to CONTROL, PERIOD and MASK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      period      <= '0;
      mask        <= MASK_ONES;
    end else if (wr_en) begin
      case (address)
        ADDR_CONTROL: begin
          ctrl_en     <= writedata[CTRL_ENABLE_BIT];
          ctrl_irq_en <= writedata[CTRL_IRQ_EN_BIT];
        end
        ADDR_PERIOD: period <= writedata[15:0];
        ADDR_MASK:   mask   <= writedata[3:0] & MASK_ONES;
        default: ;
      endcase
    end
  end

  // Registered CSR read data, one cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

  // Sticky overflow; a drop on the same edge as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else          overflow <= (overflow & ~ovf_clr) | drop;
  end

  // Period counter; a tick is held pending until the FSM is idle to take it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      tick_pend <= 1'b0;
    end else if (!ctrl_en || period_wr) begin
      cnt       <= '0;
      tick_pend <= 1'b0;
    end else if (cnt >= period) begin
      cnt       <= '0;
      tick_pend <= 1'b1;
    end else begin
      cnt       <= cnt + 16'd1;
      tick_pend <= tick_pend & (state != ST_IDLE);
    end
  end

  // Scan FSM: ISSUE/CAPTURE/COMPARE per source, registered pio_address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      k           <= '0;
      cap         <= '0;
      primed      <= '0;
      pio_address <= PIO_ADDR_IDLE;
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (!ctrl_en) begin
      state       <= ST_IDLE;
      k           <= '0;
      primed      <= '0;
      pio_address <= PIO_ADDR_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_pend) begin
            state       <= ST_ISSUE;
            pio_address <= PIO_ADDR_DATA;
          end
        end
        ST_ISSUE: begin
          state       <= ST_CAPTURE;
          pio_address <= PIO_ADDR_IDLE;
        end
        ST_CAPTURE: begin
          cap   <= src_data;
          state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          shadow[k] <= cap;
          primed[k] <= 1'b1;
          if (k == LAST_SRC) begin
            k     <= '0;
            state <= ST_IDLE;
          end else begin
            k           <= k + 1'b1;
            state       <= ST_ISSUE;
            pio_address <= PIO_ADDR_DATA;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  niosbase_pio_poller_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_ev),
    .pop       (pop),
    .pop_data  (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_niosbase_pio_poller.sv
// Directed bench for the PIO poller with registered PIO slave models.
module tb_niosbase_pio_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata_0, pio_readdata_1, pio_readdata_2, pio_readdata_3;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  logic [31:0] src_val [4];
  int          checks    = 0;
  int          failures  = 0;
  int          issue_cnt = 0;

  always #5 clk = ~clk;

  niosbase_pio_poller #(
    .NUM_SRC    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_address    (pio_address),
    .pio_readdata_0 (pio_readdata_0),
    .pio_readdata_1 (pio_readdata_1),
    .pio_readdata_2 (pio_readdata_2),
    .pio_readdata_3 (pio_readdata_3),
    .address        (address),
    .chipselect     (chipselect),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .readdata       (readdata),
    .irq            (irq)
  );

  // Registered PIO slaves: data word at address 0, junk otherwise
  always @(posedge clk) begin
    pio_readdata_0 <= (pio_address == 2'd0) ? src_val[0] : 32'hDEAD_0000;
    pio_readdata_1 <= (pio_address == 2'd0) ? src_val[1] : 32'hDEAD_0001;
    pio_readdata_2 <= (pio_address == 2'd0) ? src_val[2] : 32'hDEAD_0002;
    pio_readdata_3 <= (pio_address == 2'd0) ? src_val[3] : 32'hDEAD_0003;
  end

  // Count cycles in which a data read is presented to the slaves
  always @(negedge clk) begin
    if (reset_n && pio_address == 2'd0) issue_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return at the negedge of the first ISSUE of a scan (preceded by an idle gap)
  task automatic wait_scan_start(output bit ok);
    int gap;
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pio_address == 2'd0) begin
        if (gap >= 3) begin
          ok = 1'b1;
          break;
        end
        gap = 0;
      end else begin
        gap++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=0x%08h expected=0x%08h", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int  n0;
    bit  ok;
    for (int i = 0; i < 4; i++) src_val[i] = 32'h0;
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 3'd0; writedata = 32'h0;
    wait_cycles(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_pio_addr", {30'b0, pio_address}, 32'h1);
    @(negedge clk) reset_n = 1'b1;
    read_check("rst_control", 3'd0, 32'h0);
    read_check("rst_period",  3'd1, 32'h0);
    read_check("rst_status",  3'd2, 32'h1);
    read_check("rst_mask",    3'd5, 32'hF);
    read_check("addr6_zero",  3'd6, 32'h0);

    // Constant inputs: scans run but produce nothing
    csr_write(3'd1, 32'd10);
    csr_write(3'd0, 32'h3);
    read_check("control_rb", 3'd0, 32'h3);
    n0 = issue_cnt;
    wait_cycles(100);
    check("five_scans", {31'b0, (issue_cnt - n0) >= 20}, 32'h1);
    read_check("const_status", 3'd2, 32'h1);
    check("const_irq", {31'b0, irq}, 32'h0);

    // Single change on source 2
    src_val[2] = 32'hA5A5_0001;
    wait_cycles(40);
    check("chg2_irq", {31'b0, irq}, 32'h1);
    read_check("chg2_status", 3'd2, 32'h10);
    read_check("chg2_src",    3'd4, 32'h2);
    read_check("chg2_data",   3'd3, 32'hA5A5_0001);
    read_check("chg2_empty",  3'd2, 32'h1);
    check("chg2_irq_off", {31'b0, irq}, 32'h0);
    read_check("empty_pop",   3'd3, 32'h0);

    // Masking
    csr_write(3'd5, 32'hD);
    src_val[1] = 32'h0000_1111;
    wait_cycles(40);
    read_check("mask1_status", 3'd2, 32'h1);
    src_val[3] = 32'h0000_3333;
    wait_cycles(40);
    read_check("mask3_status", 3'd2, 32'h10);
    read_check("mask3_src",    3'd4, 32'h3);
    read_check("mask3_data",   3'd3, 32'h3333);
    read_check("mask3_empty",  3'd2, 32'h1);

    // Overflow: six events into a four-entry FIFO
    for (int v = 0; v < 6; v++) begin
      src_val[0] = 32'h100 + v;
      wait_cycles(40);
    end
    read_check("ovf_status", 3'd2, 32'h42);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    csr_write(3'd2, 32'h2);
    read_check("ovf_cleared", 3'd2, 32'h40);
    check("ovf_irq_held", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      read_check($sformatf("ovf_src%0d", i),  3'd4, 32'h0);
      read_check($sformatf("ovf_data%0d", i), 3'd3, 32'h100 + i);
    end
    read_check("ovf_drained", 3'd2, 32'h1);
    check("ovf_irq_off", {31'b0, irq}, 32'h0);

    // Disable while source 1 is being captured
    csr_write(3'd5, 32'hF);
    wait_scan_start(ok);
    check("sync_scan", {31'b0, ok}, 32'h1);
    src_val[1] = 32'h0000_2222;
    wait_cycles(2);
    csr_write(3'd0, 32'h2);
    n0 = issue_cnt;
    wait_cycles(20);
    check("dis_no_issue", issue_cnt - n0, 32'h0);
    read_check("dis_status", 3'd2, 32'h1);
    csr_write(3'd0, 32'h3);
    n0 = issue_cnt;
    wait_cycles(60);
    check("reen_scans", {31'b0, (issue_cnt - n0) > 0}, 32'h1);
    read_check("reen_status", 3'd2, 32'h1);

    // Reset mid-scan with two queued events
    src_val[0] = 32'h200;
    src_val[2] = 32'h222;
    wait_cycles(40);
    read_check("two_queued", 3'd2, 32'h20);
    wait_scan_start(ok);
    check("sync_rst", {31'b0, ok}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("arst_readdata", readdata, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_pio_addr", {30'b0, pio_address}, 32'h1);
    wait_cycles(2);
    reset_n = 1'b1;
    read_check("arst_status",  3'd2, 32'h1);
    read_check("arst_control", 3'd0, 32'h0);
    read_check("arst_mask",    3'd5, 32'hF);
    read_check("arst_period",  3'd1, 32'h0);
    read_check("arst_data",    3'd3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
